// File: rtl/eth_rx_frame_fifo_if.sv
// ---------------------------------------------------------------------------
// eth_rx_frame_fifo_if
// Byte-wide AXI-stream bundle used on both sides of the receive frame FIFO.
//   tdata  : frame byte
//   tvalid : beat valid
//   tready : sink ready (tied high by a sink that cannot stall)
//   tlast  : last byte of frame
//   tuser  : frame error, meaningful on the tlast beat
// master drives data/flags and samples tready; slave is the reverse.
// ---------------------------------------------------------------------------
interface eth_rx_frame_fifo_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser, output tready);
endinterface

// File: rtl/eth_rx_frame_fifo.sv
// ---------------------------------------------------------------------------
// eth_rx_frame_fifo
// Store-and-forward frame buffer behind the 1G MAC receive stream (rx_clk).
// Every input beat is absorbed (no backpressure upstream). Frames are only
// made visible to the read side once their tlast beat commits them; bad
// frames (optionally) and frames that run out of space are discarded.
//
// Ports:
//   clk, rst_n          receive clock, asynchronous active-low reset
//   s_axis (slave)      MAC receive stream; tready is tied to 1
//   m_axis (master)     backpressured output stream of complete frames
//   status_overflow     1-cycle pulse: frame dropped for lack of space
//   status_bad_frame    1-cycle pulse: frame received with tuser=1
//   status_good_frame   1-cycle pulse: frame committed
// ---------------------------------------------------------------------------
module eth_rx_frame_fifo #(
    parameter int DEPTH          = 4096,
    parameter bit DROP_BAD_FRAME = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    eth_rx_frame_fifo_if.slave     s_axis,
    eth_rx_frame_fifo_if.master    m_axis,
    output logic                   status_overflow,
    output logic                   status_bad_frame,
    output logic                   status_good_frame
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef enum logic {IDLE, DROP} state_t;

    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

    // {tuser, tlast, tdata}
    logic [9:0] mem [DEPTH];

    state_t state, state_nxt;
    ptr_t   wr_ptr, wr_ptr_nxt;       // committed frames end here
    ptr_t   wr_ptr_cur, wr_ptr_cur_nxt; // speculative write position
    ptr_t   wr_ptr_rd;                // committed pointer as seen by the read side
    ptr_t   rd_ptr;
    logic   wr_en;
    logic   good_nxt, bad_nxt, ovf_nxt;
    logic   full, empty, load;
    logic   wr_tuser;

    // The MAC cannot be stalled.
    assign s_axis.tready = 1'b1;

    // Full is judged against the current rd_ptr; a read in the same cycle is
    // simply not credited until the next one.
    assign full  = (wr_ptr_cur - rd_ptr) == DEPTH_P;
    // The read side sees commits one cycle late so the RAM write of the tlast
    // byte is settled well before it is read.
    assign empty = (wr_ptr_rd == rd_ptr);
    assign load  = !empty && (!m_axis.tvalid || m_axis.tready);

    // When bad frames are dropped, nothing that reaches the RAM ever carries
    // an error, so the stored flag is forced low.
    assign wr_tuser = DROP_BAD_FRAME ? 1'b0 : (s_axis.tuser & s_axis.tlast);

    // ---------------- write FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            wr_ptr            <= '0;
            wr_ptr_cur        <= '0;
            wr_ptr_rd         <= '0;
            status_good_frame <= 1'b0;
            status_bad_frame  <= 1'b0;
            status_overflow   <= 1'b0;
        end else begin
            state             <= state_nxt;
            wr_ptr            <= wr_ptr_nxt;
            wr_ptr_cur        <= wr_ptr_cur_nxt;
            wr_ptr_rd         <= wr_ptr;
            status_good_frame <= good_nxt;
            status_bad_frame  <= bad_nxt;
            status_overflow   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        wr_ptr_cur_nxt = wr_ptr_cur;
        wr_en          = 1'b0;
        good_nxt       = 1'b0;
        bad_nxt        = 1'b0;
        ovf_nxt        = 1'b0;
        if (s_axis.tvalid) begin
            case (state)
                IDLE: begin
                    if (full) begin
                        // Out of room: rewind the partial frame and discard the rest.
                        wr_ptr_cur_nxt = wr_ptr;
                        if (s_axis.tlast) ovf_nxt = 1'b1;
                        else              state_nxt = DROP;
                    end else begin
                        wr_en          = 1'b1;
                        wr_ptr_cur_nxt = wr_ptr_cur + 1'b1;
                        if (s_axis.tlast) begin
                            if (s_axis.tuser) begin
                                bad_nxt = 1'b1;
                                if (DROP_BAD_FRAME) begin
                                    wr_ptr_cur_nxt = wr_ptr;
                                end else begin
                                    wr_ptr_nxt = wr_ptr_cur + 1'b1;
                                    good_nxt   = 1'b1;
                                end
                            end else begin
                                wr_ptr_nxt = wr_ptr_cur + 1'b1;
                                good_nxt   = 1'b1;
                            end
                        end
                    end
                end
                DROP: begin
                    if (s_axis.tlast) begin
                        ovf_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // RAM contents survive reset on purpose; pointers make them invisible.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_cur[AW-1:0]] <= {wr_tuser, s_axis.tlast, s_axis.tdata};
    end

    // ---------------- read side ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= '0;
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tlast  <= 1'b0;
            m_axis.tuser  <= 1'b0;
        end else begin
            if (load) begin
                {m_axis.tuser, m_axis.tlast, m_axis.tdata} <= mem[rd_ptr[AW-1:0]];
                m_axis.tvalid <= 1'b1;
                rd_ptr        <= rd_ptr + 1'b1;
            end else if (m_axis.tready) begin
                m_axis.tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
module tb_eth_rx_frame_fifo;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic status_overflow, status_bad_frame, status_good_frame;

    eth_rx_frame_fifo_if s_if();
    eth_rx_frame_fifo_if m_if();

    eth_rx_frame_fifo #(.DEPTH(DEPTH), .DROP_BAD_FRAME(1'b1)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_axis            (s_if),
        .m_axis            (m_if),
        .status_overflow   (status_overflow),
        .status_bad_frame  (status_bad_frame),
        .status_good_frame (status_good_frame)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct {
        int   len;
        logic bad;
        int   exp_good;
        int   exp_bad;
        int   exp_ovf;
    } vec_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    good_cnt = 0, bad_cnt = 0, ovf_cnt = 0;
    int    recv_cnt = 0, last_cnt = 0;
    int    rdy_mode = 1;     // 0: tready low, 1: high, 2: random
    bit    mon_en = 1'b0;
    bit    stall_prev = 1'b0;
    logic [7:0] prev_d;
    logic       prev_l;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // tready driver
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       m_if.tready = 1'b0;
                1:       m_if.tready = 1'b1;
                default: m_if.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (status_good_frame) good_cnt++;
        if (status_bad_frame)  bad_cnt++;
        if (status_overflow)   ovf_cnt++;
        if (!mon_en) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_d || m_if.tlast !== prev_l) begin
                    errors++;
                    $display("FAIL hold: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                             m_if.tvalid, m_if.tdata, m_if.tlast, prev_d, prev_l);
                end
            end
            if (m_if.tvalid && m_if.tready) begin
                recv_cnt++;
                if (m_if.tlast) last_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got d=%0h l=%0b expected no output", m_if.tdata, m_if.tlast);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if (m_if.tdata !== e.d || m_if.tlast !== e.l || m_if.tuser !== 1'b0) begin
                        errors++;
                        $display("FAIL beat: got d=%0h l=%0b u=%0b expected d=%0h l=%0b u=0",
                                 m_if.tdata, m_if.tlast, m_if.tuser, e.d, e.l);
                    end
                end
            end
            stall_prev = m_if.tvalid && !m_if.tready;
            prev_d     = m_if.tdata;
            prev_l     = m_if.tlast;
        end
    end

    // Drives one frame; returns at posedge+1 after the tlast beat was sampled.
    task automatic send_frame(input int len, input logic [7:0] base, input logic bad, input logic push);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            s_if.tvalid = 1'b1;
            s_if.tdata  = base + 8'(i);
            s_if.tlast  = (i == len - 1);
            s_if.tuser  = bad && (i == len - 1);
        end
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        if (push)
            for (int i = 0; i < len; i++) exp_q.push_back({base + 8'(i), 1'(i == len - 1)});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_tvalid"}, 32'(m_if.tvalid), 32'd0);
        chk({name, "_tdata"},  32'(m_if.tdata),  32'd0);
        chk({name, "_tlast"},  32'(m_if.tlast),  32'd0);
        chk({name, "_tuser"},  32'(m_if.tuser),  32'd0);
        chk({name, "_status"}, 32'({status_overflow, status_bad_frame, status_good_frame}), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int g0, b0, o0, r0, l0, n, len;
        logic bad;

        vecs[0] = '{len: 60, bad: 1'b1, exp_good: 0, exp_bad: 1, exp_ovf: 0};
        vecs[1] = '{len: 20, bad: 1'b0, exp_good: 1, exp_bad: 0, exp_ovf: 0};
        vecs[2] = '{len: 64, bad: 1'b0, exp_good: 1, exp_bad: 0, exp_ovf: 0};
        vecs[3] = '{len: 65, bad: 1'b0, exp_good: 0, exp_bad: 0, exp_ovf: 1};
        vecs[4] = '{len: 17, bad: 1'b0, exp_good: 1, exp_bad: 0, exp_ovf: 0};
        vecs[5] = '{len: 1,  bad: 1'b0, exp_good: 1, exp_bad: 0, exp_ovf: 0};
        vecs[6] = '{len: 1,  bad: 1'b1, exp_good: 0, exp_bad: 1, exp_ovf: 0};

        rst_n = 1'b0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        // 60-byte good frame, latency of the first output byte
        send_frame(60, 8'h00, 1'b0, 1'b1);
        chk("t1_good_pulse", 32'(status_good_frame), 32'd1);
        chk("t1_tvalid_e0",  32'(m_if.tvalid), 32'd0);
        @(posedge clk); #1;
        chk("t1_good_pulse_end", 32'(status_good_frame), 32'd0);
        chk("t1_tvalid_e1",  32'(m_if.tvalid), 32'd0);
        @(posedge clk); #1;
        chk("t1_tvalid_e2",  32'(m_if.tvalid), 32'd1);
        chk("t1_tdata_e2",   32'(m_if.tdata),  32'h00);
        r0 = recv_cnt;
        drain("t1_drain");
        chk("t1_bytes", 32'(recv_cnt - r0), 32'd60);
        chk("t1_good_cnt", 32'(good_cnt), 32'd1);

        // table-driven single frames from an empty FIFO
        for (int v = 0; v < 7; v++) begin
            g0 = good_cnt; b0 = bad_cnt; o0 = ovf_cnt;
            send_frame(vecs[v].len, 8'(v * 16), vecs[v].bad, 1'(vecs[v].exp_good));
            repeat (4) @(posedge clk);
            #1;
            chk($sformatf("vec%0d_good", v), 32'(good_cnt - g0), 32'(vecs[v].exp_good));
            chk($sformatf("vec%0d_bad",  v), 32'(bad_cnt - b0),  32'(vecs[v].exp_bad));
            chk($sformatf("vec%0d_ovf",  v), 32'(ovf_cnt - o0),  32'(vecs[v].exp_ovf));
            drain($sformatf("vec%0d_drain", v));
        end

        // stalled output: third frame overflows
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        g0 = good_cnt; o0 = ovf_cnt; r0 = recv_cnt; l0 = last_cnt;
        send_frame(30, 8'h10, 1'b0, 1'b1);
        send_frame(30, 8'h50, 1'b0, 1'b1);
        send_frame(10, 8'hC0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_ovf", 32'(ovf_cnt - o0), 32'd1);
        chk("t3_good", 32'(good_cnt - g0), 32'd2);
        chk("t3_nothing_out", 32'(recv_cnt - r0), 32'd0);
        rdy_mode = 1;
        drain("t3_drain");
        chk("t3_bytes", 32'(recv_cnt - r0), 32'd60);
        chk("t3_frames", 32'(last_cnt - l0), 32'd2);

        // random tready, paced so no frame overflows; every 7th frame is bad
        rdy_mode = 2;
        g0 = good_cnt; b0 = bad_cnt; o0 = ovf_cnt;
        for (int f = 0; f < 100; f++) begin
            len = $urandom_range(1, 40);
            bad = (f % 7 == 3);
            n = 0;
            while (exp_q.size() + len > DEPTH && n < 2000) begin
                @(posedge clk);
                n++;
            end
            if (n >= 2000) chk("t5_pace_timeout", 32'(n), 32'd0);
            send_frame(len, 8'(f * 7), bad, !bad);
        end
        drain("t5_drain");
        chk("t5_good", 32'(good_cnt - g0), 32'd86);
        chk("t5_bad",  32'(bad_cnt - b0),  32'd14);
        chk("t5_ovf",  32'(ovf_cnt - o0),  32'd0);

        // reset mid-frame while the output is stalled
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        send_frame(30, 8'h40, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_stalled_valid", 32'(m_if.tvalid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            s_if.tvalid = 1'b1; s_if.tdata = 8'hE0 + 8'(i); s_if.tlast = 1'b0; s_if.tuser = 1'b0;
        end
        @(posedge clk); #1;
        mon_en = 1'b0;
        rst_n = 1'b0;
        s_if.tvalid = 1'b0;
        #1;
        check_reset_outputs("t6_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        r0 = recv_cnt; l0 = last_cnt;
        send_frame(3, 8'h80, 1'b0, 1'b1);   // tail of the interrupted frame
        send_frame(5, 8'hA0, 1'b0, 1'b1);
        rdy_mode = 1;
        drain("t6_drain");
        chk("t6_bytes", 32'(recv_cnt - r0), 32'd8);
        chk("t6_frames", 32'(last_cnt - l0), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
